// File: rtl/diagonal_pkg.sv
// Shared types and helpers for the diagonal walker: sweep FSM states and
// saturating arithmetic on lane registers.
package diagonal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int kmax(input int w);
    return (1 << w) - 1;
  endfunction

  // Saturating add: min(v + s, 2^w - 1).
  function automatic int sat_add(input int v, input int s, input int w);
    int t;
    t = v + s;
    return (t > kmax(w)) ? kmax(w) : t;
  endfunction

endpackage

// File: rtl/diagonal_lane.sv
// One X/Y register pair walking the X==Y diagonal toward KMAX, with
// realignment after a disturbance on Y.
module diagonal_lane
  import diagonal_pkg::*;
#(
  parameter int W    = 4,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         run,
  input  logic         kick,
  output logic [W-1:0] X,
  output logic [W-1:0] Y,
  output logic         lt,
  output logic         fin
);

  localparam logic [W-1:0] KMAX   = W'(kmax(W));
  localparam logic [W-1:0] HALF   = KMAX >> 1;
  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] x_sat;
  logic [W-1:0] y_sat;

  assign x_sat = W'(sat_add(int'(X), STEP, W));
  assign y_sat = W'(sat_add(int'(Y), STEP, W));
  assign lt    = (X < Y);
  assign fin   = (X == KMAX) && (Y == KMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      X <= '0;
      Y <= '0;
    end else if (clr) begin
      X <= '0;
      Y <= '0;
    end else if (run) begin
      if (kick) begin
        Y <= Y + STEP_W;
      end else if (X > Y) begin
        // Pull X halfway back toward the top while Y climbs to meet it.
        X <= HALF + (X >> 1);
        Y <= y_sat;
      end else if (X < Y) begin
        X <= Y;
      end else if (X != KMAX) begin
        X <= x_sat;
        Y <= x_sat;
      end
    end
  end

endmodule

// File: rtl/diagonal_walker.sv
// Multi-lane diagonal walker: sweep FSM, saturating sweep counter, the
// !(X<Y) property reduction and a sticky first-violation monitor.
//   state | meaning
//   IDLE  | waiting for start; lanes hold
//   RUN   | lanes update each edge until stop or all lanes finished
//   DONE  | one-cycle done pulse, returns to IDLE
module diagonal_walker
  import diagonal_pkg::*;
#(
  parameter int W     = 4,
  parameter int LANES = 4,
  parameter int STEP  = 1,
  parameter int CNT_W = 8,
  localparam int VL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [LANES-1:0]   perturb,
  output logic [LANES*W-1:0] X,
  output logic [LANES*W-1:0] Y,
  output logic               busy,
  output logic               done,
  output logic               prop,
  output logic               viol_sticky,
  output logic [VL_W-1:0]    viol_lane,
  output logic [CNT_W-1:0]   sweep_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             clr;
  logic             run_go;
  logic             all_done;
  logic [LANES-1:0] lt;
  logic [LANES-1:0] fin;
  logic [VL_W-1:0]  low_lane;

  assign clr      = (state_q == IDLE) && start;
  assign run_go   = (state_q == RUN) && !stop;
  assign all_done = (&fin) && (perturb == '0);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign prop     = ~|lt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    diagonal_lane #(.W(W), .STEP(STEP)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .run   (run_go),
      .kick  (perturb[i]),
      .X     (X[i*W +: W]),
      .Y     (Y[i*W +: W]),
      .lt    (lt[i]),
      .fin   (fin[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop || all_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_cnt <= '0;
    end else if (clr) begin
      sweep_cnt <= '0;
    end else if (state_q == RUN && sweep_cnt != CNT_MAX) begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // Downward scan so the lowest failing lane wins.
  always_comb begin
    low_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lt[i]) low_lane = VL_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      viol_sticky <= 1'b0;
      viol_lane   <= '0;
    end else if (clr) begin
      viol_sticky <= 1'b0;
      viol_lane   <= '0;
    end else if (!prop && !viol_sticky) begin
      viol_sticky <= 1'b1;
      viol_lane   <= low_lane;
    end
  end

endmodule

// File: tb/tb_diagonal_walker.sv
// Directed bench for diagonal_walker: walk, perturbation recovery, stop,
// mid-run reset and a STEP=3 instance entered with start and stop together.
module tb_diagonal_walker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [3:0]  perturb = '0;
  logic [15:0] X, Y;
  logic        busy, done, prop, viol_sticky;
  logic [1:0]  viol_lane;
  logic [7:0]  sweep_cnt;

  logic        start6 = 1'b0, stop6 = 1'b0;
  logic [3:0]  perturb6 = '0;
  logic [15:0] X6, Y6;
  logic        busy6, done6, prop6, viol_sticky6;
  logic [1:0]  viol_lane6;
  logic [7:0]  sweep_cnt6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  diagonal_walker #(.W(4), .LANES(4), .STEP(1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .perturb(perturb),
    .X(X), .Y(Y), .busy(busy), .done(done), .prop(prop),
    .viol_sticky(viol_sticky), .viol_lane(viol_lane), .sweep_cnt(sweep_cnt)
  );

  diagonal_walker #(.W(4), .LANES(4), .STEP(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .start(start6), .stop(stop6), .perturb(perturb6),
    .X(X6), .Y(Y6), .busy(busy6), .done(done6), .prop(prop6),
    .viol_sticky(viol_sticky6), .viol_lane(viol_lane6), .sweep_cnt(sweep_cnt6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {4'(l3), 4'(l2), 4'(l1), 4'(l0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; stop = 0; perturb = '0;
    start6 = 0; stop6 = 0; perturb6 = '0;
    reset = 1;
    #2;
    reset = 0;
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_x", X, 16'h0);
    chk("rst_y", Y, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prop", prop, 1'b1);
    chk("rst_sticky", viol_sticky, 1'b0);
    chk("rst_cnt", sweep_cnt, 8'd0);

    // stop in IDLE is ignored
    stop = 1; step(); stop = 0;
    chk("idle_stop_busy", busy, 1'b0);

    // 1: plain walk
    start = 1; step(); start = 0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_x0", X, 16'h0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("t1_x_%0d", k), X, pk(k, k, k, k));
      chk($sformatf("t1_y_%0d", k), Y, pk(k, k, k, k));
      chk($sformatf("t1_prop_%0d", k), prop, 1'b1);
    end
    chk("t1_busy15", busy, 1'b1);
    step();
    chk("t1_done", done, 1'b1);
    chk("t1_cnt", sweep_cnt, 8'd16);
    chk("t1_busy_off", busy, 1'b0);
    step();
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);

    // 2: perturb lane 2 at X=Y=5
    do_reset();
    start = 1; step(); start = 0;
    repeat (5) step();
    chk("t2_at5", X, pk(5, 5, 5, 5));
    perturb = 4'b0100; step(); perturb = '0;
    chk("t2_x", X, pk(6, 6, 5, 6));
    chk("t2_y", Y, pk(6, 6, 6, 6));
    chk("t2_prop0", prop, 1'b0);
    chk("t2_sticky0", viol_sticky, 1'b0);
    step();
    chk("t2_sticky1", viol_sticky, 1'b1);
    chk("t2_lane", viol_lane, 2'd2);
    chk("t2_x_realign", X, pk(7, 7, 6, 7));
    chk("t2_y_realign", Y, pk(7, 7, 6, 7));
    chk("t2_prop1", prop, 1'b1);
    step();
    chk("t2_sticky_hold", viol_sticky, 1'b1);
    chk("t2_lane_hold", viol_lane, 2'd2);
    chk("t2_x_next", X, pk(8, 8, 7, 8));

    // 3: perturb lane 0 at the top
    do_reset();
    start = 1; step(); start = 0;
    repeat (15) step();
    chk("t3_top", X, pk(15, 15, 15, 15));
    perturb = 4'b0001; step(); perturb = '0;
    chk("t3_x16", X, pk(15, 15, 15, 15));
    chk("t3_y16", Y, pk(0, 15, 15, 15));
    chk("t3_busy16", busy, 1'b1);
    chk("t3_prop16", prop, 1'b1);
    step();
    chk("t3_x17", X, pk(14, 15, 15, 15));
    chk("t3_y17", Y, pk(1, 15, 15, 15));
    for (int e = 18; e <= 30; e++) begin
      step();
      chk($sformatf("t3_x_%0d", e), X, pk(14, 15, 15, 15));
      chk($sformatf("t3_y_%0d", e), Y, pk(e - 16, 15, 15, 15));
      chk($sformatf("t3_prop_%0d", e), prop, 1'b1);
    end
    step();
    chk("t3_x31", X, pk(15, 15, 15, 15));
    chk("t3_y31", Y, pk(15, 15, 15, 15));
    chk("t3_busy31", busy, 1'b1);
    step();
    chk("t3_done", done, 1'b1);
    chk("t3_cnt", sweep_cnt, 8'd32);
    chk("t3_sticky", viol_sticky, 1'b0);

    // 4: stop at X=Y=3
    do_reset();
    start = 1; step(); start = 0;
    repeat (3) step();
    stop = 1; step(); stop = 0;
    chk("t4_x", X, pk(3, 3, 3, 3));
    chk("t4_y", Y, pk(3, 3, 3, 3));
    chk("t4_done", done, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_cnt", sweep_cnt, 8'd4);
    start = 1; step(); start = 0;
    chk("t4_done_off", done, 1'b0);
    chk("t4_busy_off", busy, 1'b0);
    chk("t4_cnt_frozen", sweep_cnt, 8'd4);
    chk("t4_x_hold", X, pk(3, 3, 3, 3));

    // 5: async reset mid-run after a violation
    do_reset();
    start = 1; step(); start = 0;
    repeat (3) step();
    perturb = 4'b0010; step(); perturb = '0;
    step();
    chk("t5_sticky", viol_sticky, 1'b1);
    chk("t5_lane", viol_lane, 2'd1);
    #2 reset = 1;
    #1;
    chk("t5_x", X, 16'h0);
    chk("t5_y", Y, 16'h0);
    chk("t5_sticky_clr", viol_sticky, 1'b0);
    chk("t5_lane_clr", viol_lane, 2'd0);
    chk("t5_cnt", sweep_cnt, 8'd0);
    chk("t5_busy", busy, 1'b0);
    reset = 0;
    start = 1; step(); start = 0;
    chk("t5_restart_busy", busy, 1'b1);
    chk("t5_restart_x", X, 16'h0);
    step();
    chk("t5_restart_x1", X, pk(1, 1, 1, 1));

    // 6: STEP=3 instance, start and stop together in IDLE
    do_reset();
    start6 = 1; stop6 = 1; step(); start6 = 0; stop6 = 0;
    chk("t6_busy", busy6, 1'b1);
    chk("t6_x0", X6, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("t6_x_%0d", k), X6, pk(3 * k, 3 * k, 3 * k, 3 * k));
      chk($sformatf("t6_y_%0d", k), Y6, pk(3 * k, 3 * k, 3 * k, 3 * k));
    end
    step();
    chk("t6_done", done6, 1'b1);
    chk("t6_cnt", sweep_cnt6, 8'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
